cache_flush_walker: RTL

- Flush/writeback sequencer: the consumer side of the FlushCache request that the replacement-policy logic only observes.
- On a flush command it walks every set and way of the cache tag/dirty arrays.
- Each valid-and-dirty line is issued to the bus writeback engine over a valid/ready handshake, then its dirty bit is cleared.
- Sits between the cache controller FSM, the tag/dirty arrays (synchronous 1-cycle read), and the writeback/AHB interface.

---
 rtl/cache_flush_walker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cache_flush_walker.sv
// rtl/cache_flush_walker.sv - full-cache flush sequencer: walks sets/ways and writes back valid dirty lines
module cache_flush_walker #(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FlushStart,
    output logic [SETLEN-1:0]  FlushSet,
    output logic               FlushReadEn,
    input  logic [NUMWAYS-1:0] DirtyWay,
    input  logic [NUMWAYS-1:0] ValidWay,
    output logic [NUMWAYS-1:0] FlushWay,
    output logic               WbReq,
    input  logic               WbReady,
    output logic               ClearDirty,
    output logic               FlushBusy,
    output logic               FlushDone
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SELECT,
        WB,
        CLEAR,
        DONE
    } flush_state_t;

    localparam logic [SETLEN-1:0] LASTSET = SETLEN'(NUMLINES - 1);

    flush_state_t        state;
    flush_state_t        stateNext;
    logic [SETLEN-1:0]   setNext;
    logic [NUMWAYS-1:0]  wayNext;
    logic [NUMWAYS-1:0]  PendingMask;
    logic [NUMWAYS-1:0]  maskNext;
    logic [NUMWAYS-1:0]  lowestPending;

    // Two's-complement trick isolates the lowest set bit, so ways drain in ascending order.
    assign lowestPending = PendingMask & (~PendingMask + NUMWAYS'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            FlushSet    <= '0;
            FlushWay    <= '0;
            PendingMask <= '0;
        end else begin
            state       <= stateNext;
            FlushSet    <= setNext;
            FlushWay    <= wayNext;
            PendingMask <= maskNext;
        end
    end

    always_comb begin
        stateNext   = state;
        setNext     = FlushSet;
        wayNext     = FlushWay;
        maskNext    = PendingMask;
        FlushReadEn = 1'b0;
        WbReq       = 1'b0;
        ClearDirty  = 1'b0;
        FlushDone   = 1'b0;
        FlushBusy   = (state != IDLE);

        unique case (state)
            IDLE: begin
                if (FlushStart) begin
                    setNext   = '0;
                    stateNext = READ;
                end
            end
            READ: begin
                FlushReadEn = 1'b1;
                stateNext   = CAPTURE;
            end
            CAPTURE: begin
                // Array data for FlushSet is valid only in this cycle.
                maskNext  = DirtyWay & ValidWay;
                stateNext = SELECT;
            end
            SELECT: begin
                if (PendingMask == '0) begin
                    if (FlushSet == LASTSET) begin
                        stateNext = DONE;
                    end else begin
                        setNext   = FlushSet + SETLEN'(1);
                        stateNext = READ;
                    end
                end else begin
                    wayNext   = lowestPending;
                    stateNext = WB;
                end
            end
            WB: begin
                WbReq = 1'b1;
                if (WbReady) begin
                    stateNext = CLEAR;
                end
            end
            CLEAR: begin
                ClearDirty = 1'b1;
                maskNext   = PendingMask & ~FlushWay;
                wayNext    = '0;
                stateNext  = SELECT;
            end
            DONE: begin
                FlushDone = 1'b1;
                setNext   = '0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
